calc_sequencer: RTL

Instruction sequencer that sits directly upstream of the simple calculator (8×8 register file + ALU). It buffers packed 24-bit micro-instructions from a valid/ready source and issues at most one per cycle onto the calculator's WEN/RW/RX/RY/DataIn/Sel/Ctrl inputs. It also tracks the calculator's Carry output for conditional skip, and supports a halt/resume mechanism.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_instr_fifo.sv | 55 +++++
 rtl/calc_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator instruction sequencer:
// instruction field positions, Ctrl opcodes and the sequencer state enum.
package calc_pkg;

    localparam int INSTR_W  = 24;

    // Packed micro-instruction layout
    localparam int SKIP_BIT = 23;
    localparam int WEN_BIT  = 22;
    localparam int RW_LSB   = 19;
    localparam int RX_LSB   = 16;
    localparam int RY_LSB   = 13;
    localparam int SEL_BIT  = 12;
    localparam int CTRL_LSB = 8;
    localparam int DATA_LSB = 0;

    // Ctrl opcodes the sequencer cares about
    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    // True when the ALU operation produces a meaningful carry
    function automatic logic is_addsub(input logic [3:0] ctrl);
        return (ctrl == CTRL_ADD) || (ctrl == CTRL_SUB);
    endfunction

endpackage

// File: rtl/calc_instr_fifo.sv
// Instruction FIFO: DEPTH x WIDTH, pointers carry one extra MSB so that
// full and empty are distinguished without a separate occupancy counter.
// The head entry is read combinationally so the sequencer can load it
// into its output registers on the same edge it pops.
module calc_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Storage array: written at the tail, no reset needed
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset empties the FIFO
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Instruction sequencer feeding the 8x8 register-file calculator.
// Buffers 24-bit micro-instructions, issues one per cycle onto registered
// calculator controls, tracks a sticky carry and supports HALT/resume.
// Optional feature macro: CALC_SEQ_SKIP_EN (conditional skip on carry).
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               resume,
    input  logic               Carry,
    output logic               WEN,
    output logic [2:0]         RW,
    output logic [2:0]         RX,
    output logic [2:0]         RY,
    output logic [7:0]         DataIn,
    output logic               Sel,
    output logic [3:0]         Ctrl,
    output logic               carry_flag,
    output logic               halted,
    output logic [CNT_W-1:0]   issue_cnt
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_ONE = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t         state_reg;
    seq_state_t         state_next;
    logic [INSTR_W-1:0] head;
    logic [OCC_W-1:0]   occ;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_en;
    logic               pop_en;
    logic               head_halt;
    logic               skip_hit;
    logic               exec_en;
    logic               drv_skip_reg;   // currently driven instruction was skipped

    calc_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .push  (push_en),
        .wdata (in_instr),
        .pop   (pop_en),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

    // in_ready looks only at full, so a same-cycle pop never opens the gate
    assign in_ready  = !fifo_full;
    assign push_en   = in_valid && in_ready;
    assign pop_en    = (state_reg != ST_HALTED) && !fifo_empty;
    assign head_halt = !head[WEN_BIT] && (head[CTRL_LSB +: 4] == CTRL_HALT);
    assign halted    = (state_reg == ST_HALTED);

`ifdef CALC_SEQ_SKIP_EN
    // Carry of the instruction on the calculator right now, or the sticky
    // value when that instruction is not an add/sub
    logic eff_carry;
    assign eff_carry = is_addsub(Ctrl) ? Carry : carry_flag;
    assign skip_hit  = pop_en && head[SKIP_BIT] && eff_carry;
`else
    // SKIP bit carries no meaning in this build
    assign skip_hit  = head[SKIP_BIT] & 1'b0;
`endif

    assign exec_en = pop_en && !head_halt && !skip_hit;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (pop_en && head_halt) begin
                    state_next = ST_HALTED;
                end else if (pop_en && (occ == OCC_ONE) && !push_en) begin
                    state_next = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_next = fifo_empty ? ST_IDLE : ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Calculator drive: load on pop, otherwise hold fields and drop WEN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            WEN          <= 1'b0;
            RW           <= '0;
            RX           <= '0;
            RY           <= '0;
            DataIn       <= '0;
            Sel          <= 1'b0;
            Ctrl         <= '0;
            drv_skip_reg <= 1'b0;
        end else if (pop_en) begin
            WEN          <= head[WEN_BIT] && !skip_hit;
            RW           <= head[RW_LSB +: 3];
            RX           <= head[RX_LSB +: 3];
            RY           <= head[RY_LSB +: 3];
            DataIn       <= head[DATA_LSB +: 8];
            Sel          <= head[SEL_BIT];
            Ctrl         <= head[CTRL_LSB +: 4];
            drv_skip_reg <= skip_hit;
        end else begin
            WEN          <= 1'b0;
        end
    end

    // Sticky carry follows add/sub results, except for a skipped instruction
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            carry_flag <= 1'b0;
        end else if (is_addsub(Ctrl) && !drv_skip_reg) begin
            carry_flag <= Carry;
        end
    end

    // Executed-instruction counter, free-running wrap
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            issue_cnt <= '0;
        end else if (exec_en) begin
            issue_cnt <= issue_cnt + CNT_ONE;
        end
    end

endmodule
